// File: rtl/amo_queue_pkg.sv
// Shared types for the AMO queue: operation encoding, cache request/response, queue entry and FSM state.
// Alignment helper is used only when AMO_QUEUE_ALIGN_CHECK_EN is defined.
package amo_queue_pkg;

    localparam int XLEN              = 64;
    localparam int PLEN              = 56;
    // Widest transaction ID an entry can carry; the queue's TRANS_ID_BITS must not exceed it.
    localparam int TRANS_ID_MAX_BITS = 8;

    typedef enum logic [3:0] {
        AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND,
        AMO_OR, AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU
    } amo_t;

    typedef enum logic [1:0] {IDLE, WAIT_ST, REQ} state_t;

    typedef struct packed {
        amo_t                         op;
        logic [PLEN-1:0]              paddr;
        logic [XLEN-1:0]              data;
        logic [1:0]                   size;
        logic [TRANS_ID_MAX_BITS-1:0] trans_id;
        logic                         misaligned;
    } entry_t;

    typedef struct packed {
        logic            req;
        amo_t            amo_op;
        logic [1:0]      size;
        logic [XLEN-1:0] operand_a;
        logic [XLEN-1:0] operand_b;
    } amo_req_t;

    typedef struct packed {
        logic            ack;
        logic [XLEN-1:0] result;
    } amo_resp_t;

    function automatic logic is_misaligned(input logic [PLEN-1:0] paddr, input logic [1:0] size);
        return ((size == 2'b10) && (paddr[1:0] != 2'b00)) ||
               ((size == 2'b11) && (paddr[2:0] != 3'b000));
    endfunction

endpackage

// File: rtl/amo_queue_store.sv
// Circular entry store with head/tail pointers; any DEPTH >= 1, pointers wrap at DEPTH-1 -> 0.
// Latency: push/pop take effect next cycle; flush rewinds tail to head + keep. No backpressure of its own.
module amo_queue_store
    import amo_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    input  logic          flush,
    input  logic [CW-1:0] keep,
    output entry_t        head_entry,
    output logic [CW-1:0] count
);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head, tail, head_nxt;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    assign head_nxt   = pop ? ptr_add(head, 1) : head;
    assign head_entry = mem[head];

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head_nxt;
            // keep already accounts for this cycle's pop, so it is measured from the new head
            if (flush) begin
                tail  <= ptr_add(head_nxt, int'(keep));
                count <= keep;
            end else begin
                if (push) tail <= ptr_add(tail, 1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: rtl/amo_queue.sv
// In-order AMO queue: issues committed entries to the cache once stores drain (AMO_QUEUE_ALIGN_CHECK_EN adds misalignment faults).
// Latency: commit in N with stores drained -> req in N+1; ack in M -> result in M+1.
// Backpressure: ready_o low whenever DEPTH entries are held, even while popping; one cache request outstanding.
module amo_queue
    import amo_queue_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  amo_t                       amo_op_i,
    input  logic [PLEN-1:0]            paddr_i,
    input  logic [XLEN-1:0]            data_i,
    input  logic [1:0]                 data_size_i,
    input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
    input  logic                       amo_valid_commit_i,
    input  logic                       no_st_pending_i,
    output amo_req_t                   amo_req_o,
    input  amo_resp_t                  amo_resp_i,
    output logic                       result_valid_o,
    output logic [TRANS_ID_BITS-1:0]   result_id_o,
    output logic [XLEN-1:0]            result_o,
    output logic                       misaligned_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t        state;
    logic [CW-1:0] commit_cnt, commit_nxt, count;
    entry_t        push_entry, head;
    logic          push, pop, pending, fault_done;
    logic          unused_id_bits;

    assign ready_o     = (count < CW'(DEPTH));
    assign occupancy_o = count;
    assign push        = valid_i && ready_o && !flush_i;
    // A same-cycle commit counts as pending so the request can rise in the very next cycle.
    assign pending     = (commit_cnt != '0) || (amo_valid_commit_i && (commit_cnt < count));
    assign fault_done  = (state == IDLE) && pending && head.misaligned;
    assign pop         = ((state == REQ) && amo_resp_i.ack) || fault_done;
    assign commit_nxt  = commit_cnt + CW'(amo_valid_commit_i) - CW'(pop);
    assign unused_id_bits = ^head.trans_id;

    always_comb begin
        push_entry          = '0;
        push_entry.op       = amo_op_i;
        push_entry.paddr    = paddr_i;
        push_entry.data     = data_i;
        push_entry.size     = data_size_i;
        push_entry.trans_id = TRANS_ID_MAX_BITS'(trans_id_i);
`ifdef AMO_QUEUE_ALIGN_CHECK_EN
        push_entry.misaligned = is_misaligned(paddr_i, data_size_i);
`else
        push_entry.misaligned = 1'b0;
`endif
    end

    always_comb begin
        amo_req_o           = '0;
        amo_req_o.req       = (state == REQ);
        amo_req_o.amo_op    = head.op;
        amo_req_o.size      = head.size;
        amo_req_o.operand_a = XLEN'(head.paddr);
        amo_req_o.operand_b = head.data;
    end

    amo_queue_store #(.DEPTH(DEPTH)) u_store (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush_i),
        .keep       (commit_nxt),
        .head_entry (head),
        .count      (count)
    );

`ifdef AMO_QUEUE_ALIGN_CHECK_EN
    logic fault_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) fault_q <= 1'b0;
        else       fault_q <= fault_done;
    end
    assign misaligned_o = fault_q;
`else
    assign misaligned_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            commit_cnt     <= '0;
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_o       <= '0;
        end else begin
            commit_cnt     <= commit_nxt;
            result_valid_o <= pop;
            if (pop) begin
                result_id_o <= head.trans_id[TRANS_ID_BITS-1:0];
                if (fault_done)
                    result_o <= '0;
                else if (head.size == 2'b10)
                    result_o <= {{(XLEN-32){amo_resp_i.result[31]}}, amo_resp_i.result[31:0]};
                else
                    result_o <= amo_resp_i.result;
            end
            case (state)
                IDLE:    if (pending && !head.misaligned) state <= no_st_pending_i ? REQ : WAIT_ST;
                WAIT_ST: if (no_st_pending_i) state <= REQ;
                REQ:     if (amo_resp_i.ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    commit_without_entry: assert property (@(posedge clk_i) disable iff (rst_i)
        amo_valid_commit_i |-> (commit_cnt < count));

endmodule

// File: tb/tb_amo_queue.sv
// Directed bench for amo_queue: issue latency, full queue, flush, store-drain wait, reset mid-request.
module tb_amo_queue;
    import amo_queue_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            flush_i = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    amo_t            amo_op_i = AMO_NONE;
    logic [PLEN-1:0] paddr_i = '0;
    logic [XLEN-1:0] data_i = '0;
    logic [1:0]      data_size_i = 2'b00;
    logic [2:0]      trans_id_i = '0;
    logic            amo_valid_commit_i = 1'b0;
    logic            no_st_pending_i = 1'b1;
    amo_req_t        amo_req_o;
    amo_resp_t       amo_resp_i = '0;
    logic            result_valid_o;
    logic [2:0]      result_id_o;
    logic [XLEN-1:0] result_o;
    logic            misaligned_o;
    logic [2:0]      occupancy_o;

    int checks = 0;
    int errors = 0;

    amo_queue #(.DEPTH(4), .TRANS_ID_BITS(3)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .flush_i            (flush_i),
        .valid_i            (valid_i),
        .ready_o            (ready_o),
        .amo_op_i           (amo_op_i),
        .paddr_i            (paddr_i),
        .data_i             (data_i),
        .data_size_i        (data_size_i),
        .trans_id_i         (trans_id_i),
        .amo_valid_commit_i (amo_valid_commit_i),
        .no_st_pending_i    (no_st_pending_i),
        .amo_req_o          (amo_req_o),
        .amo_resp_i         (amo_resp_i),
        .result_valid_o     (result_valid_o),
        .result_id_o        (result_id_o),
        .result_o           (result_o),
        .misaligned_o       (misaligned_o),
        .occupancy_o        (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_amo(input amo_t op, input logic [63:0] addr, input logic [63:0] dat,
                           input logic [1:0] sz, input logic [2:0] id);
        amo_op_i    = op;
        paddr_i     = addr[PLEN-1:0];
        data_i      = dat;
        data_size_i = sz;
        trans_id_i  = id;
    endtask

    task automatic enq(input amo_t op, input logic [63:0] addr, input logic [63:0] dat,
                       input logic [1:0] sz, input logic [2:0] id);
        set_amo(op, addr, dat, sz, id);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic commit1();
        amo_valid_commit_i = 1'b1;
        tick();
        amo_valid_commit_i = 1'b0;
    endtask

    task automatic ack(input logic [63:0] r);
        amo_resp_i.ack    = 1'b1;
        amo_resp_i.result = r;
        tick();
        amo_resp_i = '0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!amo_req_o.req && n < 20) begin
            tick();
            n++;
        end
        check(tag, amo_req_o.req, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        #2 rst_i = 1'b1;
        #2;
        check("rst_ready", ready_o, 1'b1);
        check("rst_occ", occupancy_o, 0);
        check("rst_req", amo_req_o.req, 1'b0);
        check("rst_rvalid", result_valid_o, 1'b0);
        check("rst_misal", misaligned_o, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;

        // 1: single AMOADD, req one cycle after commit, result one cycle after ack
        enq(AMO_ADD, 64'h40, 64'h1, 2'b11, 3'd2);
        check("t1_occ", occupancy_o, 1);
        check("t1_req_before", amo_req_o.req, 1'b0);
        commit1();
        check("t1_req", amo_req_o.req, 1'b1);
        check("t1_op", amo_req_o.amo_op, AMO_ADD);
        check("t1_opa", amo_req_o.operand_a, 64'h40);
        check("t1_opb", amo_req_o.operand_b, 64'h1);
        check("t1_size", amo_req_o.size, 2'b11);
        ack(64'h7);
        check("t1_rvalid", result_valid_o, 1'b1);
        check("t1_rid", result_id_o, 3'd2);
        check("t1_res", result_o, 64'h7);
        check("t1_misal", misaligned_o, 1'b0);
        check("t1_req_low", amo_req_o.req, 1'b0);
        check("t1_occ0", occupancy_o, 0);
        tick();
        check("t1_pulse", result_valid_o, 1'b0);

        // 2: fill, reject fifth, then drain four in order
        for (int i = 0; i < 4; i++) enq(AMO_SWAP, 64'h100 + 64'(8 * i), 64'(i), 2'b11, 3'(i));
        check("t2_ready", ready_o, 1'b0);
        check("t2_occ", occupancy_o, 4);
        enq(AMO_SWAP, 64'h500, 64'h5, 2'b11, 3'd7);
        check("t2_occ_full", occupancy_o, 4);
        for (int i = 0; i < 4; i++) commit1();
        for (int i = 0; i < 4; i++) begin
            wait_req("t2_req");
            check("t2_opa", amo_req_o.operand_a, 64'h100 + 64'(8 * i));
            ack(64'h10 + 64'(i));
            check("t2_rvalid", result_valid_o, 1'b1);
            check("t2_rid", result_id_o, 64'(i));
            check("t2_res", result_o, 64'h10 + 64'(i));
            check("t2_one_outstanding", amo_req_o.req, 1'b0);
        end
        check("t2_occ0", occupancy_o, 0);
        tick();

        // 3: commit + flush + valid together keeps only the committed word AMO
        no_st_pending_i = 1'b0;
        enq(AMO_OR, 64'h200, 64'h3, 2'b10, 3'd4);
        enq(AMO_OR, 64'h208, 64'h3, 2'b11, 3'd5);
        enq(AMO_OR, 64'h210, 64'h3, 2'b11, 3'd6);
        set_amo(AMO_XOR, 64'h218, 64'h9, 2'b11, 3'd7);
        valid_i = 1'b1;
        amo_valid_commit_i = 1'b1;
        flush_i = 1'b1;
        tick();
        valid_i = 1'b0;
        amo_valid_commit_i = 1'b0;
        flush_i = 1'b0;
        check("t3_occ", occupancy_o, 1);
        check("t3_wait", amo_req_o.req, 1'b0);
        no_st_pending_i = 1'b1;
        tick();
        check("t3_req", amo_req_o.req, 1'b1);
        check("t3_opa", amo_req_o.operand_a, 64'h200);
        check("t3_size", amo_req_o.size, 2'b10);
        ack(64'h8000_0001);
        check("t3_rid", result_id_o, 3'd4);
        check("t3_sext", result_o, 64'hFFFF_FFFF_8000_0001);
        check("t3_occ0", occupancy_o, 0);
        tick();

        // 4: stores pending for five cycles hold the request off
        no_st_pending_i = 1'b0;
        enq(AMO_AND, 64'h300, 64'hF, 2'b11, 3'd1);
        commit1();
        for (int i = 0; i < 5; i++) begin
            check("t4_held", amo_req_o.req, 1'b0);
            tick();
        end
        no_st_pending_i = 1'b1;
        tick();
        check("t4_req", amo_req_o.req, 1'b1);
        set_amo(AMO_MAX, 64'h308, 64'h2, 2'b11, 3'd5);
        valid_i = 1'b1;
        ack(64'h55);
        valid_i = 1'b0;
        check("t4_occ_push_pop", occupancy_o, 1);
        check("t4_rid", result_id_o, 3'd1);
        check("t4_res", result_o, 64'h55);

        // 5: reset while the request is outstanding; a late ack must be ignored
        commit1();
        check("t5_req", amo_req_o.req, 1'b1);
        rst_i = 1'b1;
        #1;
        check("t5_req_drop", amo_req_o.req, 1'b0);
        check("t5_occ", occupancy_o, 0);
        check("t5_ready", ready_o, 1'b1);
        tick();
        rst_i = 1'b0;
        ack(64'h99);
        check("t5_no_result", result_valid_o, 1'b0);
        check("t5_req_low", amo_req_o.req, 1'b0);
        check("t5_occ0", occupancy_o, 0);

`ifdef AMO_QUEUE_ALIGN_CHECK_EN
        // 6: misaligned double completes without a cache request or a store drain
        no_st_pending_i = 1'b0;
        enq(AMO_SWAP, 64'h44, 64'h1, 2'b11, 3'd3);
        commit1();
        check("t6_rvalid", result_valid_o, 1'b1);
        check("t6_misal", misaligned_o, 1'b1);
        check("t6_res", result_o, 64'h0);
        check("t6_rid", result_id_o, 3'd3);
        check("t6_no_req", amo_req_o.req, 1'b0);
        check("t6_occ", occupancy_o, 0);
        no_st_pending_i = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
